// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, sequencer states and helpers for muldiv_seq
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MULTU = 3'd0,
    OP_MULT  = 3'd1,
    OP_MADDU = 3'd2,
    OP_MADD  = 3'd3,
    OP_DIVU  = 3'd4,
    OP_DIV   = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_t;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  localparam int DIV_STEPS = 32;
  function automatic logic is_signed(op_t op);
    return op == OP_MULT || op == OP_MADD || op == OP_DIV;
  endfunction
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-divide iteration
module div_step (
  input  logic [31:0] rem,
  input  logic        dbit,
  input  logic [31:0] dvsr,
  output logic [31:0] rem_next,
  output logic        qbit
);
  logic [32:0] shifted, trial;
  assign shifted = {rem, dbit};
  assign trial = shifted - {1'b0, dvsr};
  // no borrow out of the 33-bit subtract means the divisor fits
  assign qbit = ~trial[32];
  assign rem_next = qbit ? trial[31:0] : shifted[31:0];
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer owning HI/LO
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [2:0]  OP,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MF_REQ,
  input  logic        MF_SEL,
  output logic        BUSY,
  output logic        STALL,
  output logic [31:0] MF_DATA,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  state_t state, state_n;
  op_t op_q, op_in;
  logic [4:0] cnt;
  logic [31:0] opa, opb, rem, rem_n;
  logic [63:0] prod, prod_n, acc_n;
  logic qneg, rneg, qbit, sgn;
  assign op_in = op_t'(OP);
  assign sgn = is_signed(op_in);
  assign prod_n = {{32{sgn & A[31]}}, A} * {{32{sgn & B[31]}}, B};
  assign acc_n = (op_q == OP_MADD || op_q == OP_MADDU) ? {HI, LO} + prod : prod;
  assign BUSY = state != IDLE;
  assign STALL = BUSY & (START | MF_REQ);
  assign MF_DATA = MF_SEL ? HI : LO;
  div_step u_step (
    .rem(rem),
    .dbit(opa[31]),
    .dvsr(opb),
    .rem_next(rem_n),
    .qbit(qbit)
  );
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !START ? IDLE : op_in inside {OP_MULTU, OP_MULT, OP_MADDU, OP_MADD} ? MUL :
                      op_in inside {OP_DIVU, OP_DIV} ? DIV : IDLE;
      MUL: state_n = cnt == 5'd0 ? IDLE : MUL;
      DIV: state_n = cnt == 5'd0 ? FIX : DIV;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      HI <= '0;
      LO <= '0;
      op_q <= OP_MULTU;
      cnt <= '0;
      opa <= '0;
      opb <= '0;
      rem <= '0;
      prod <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START) begin
          op_q <= op_in;
          case (op_in)
            OP_MTHI: HI <= A;
            OP_MTLO: LO <= A;
            OP_DIVU, OP_DIV: begin
              opa <= sgn & A[31] ? -A : A;
              opb <= sgn & B[31] ? -B : B;
              rem <= '0;
              // raw A parked here for the divide-by-zero HI result
              prod <= {32'd0, A};
              qneg <= sgn & (A[31] ^ B[31]);
              rneg <= sgn & A[31];
              cnt <= 5'(DIV_STEPS - 1);
            end
            default: begin
              opa <= A;
              opb <= B;
              prod <= prod_n;
              cnt <= 5'(MUL_LAT - 1);
            end
          endcase
        end
        MUL: if (cnt == 5'd0) {HI, LO} <= acc_n;
             else cnt <= cnt - 5'd1;
        DIV: begin
          rem <= rem_n;
          opa <= {opa[30:0], qbit};
          cnt <= cnt - 5'd1;
        end
        default: if (opb == '0) begin
          LO <= 32'hFFFF_FFFF;
          HI <= prod[31:0];
        end else begin
          LO <= qneg ? -opa : opa;
          HI <= rneg ? -rem : rem;
        end
      endcase
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer for the CPU execute stage; owns the architectural HI/LO registers.
- Accepts one MULT/MULTU/MADD/MADDU/DIV/DIVU/MTHI/MTLO operation at a time.
- Runs multiplies with a fixed latency and divides as a 32-step restoring divider.
- Stalls the pipeline when a new op or an MFHI/MFLO read arrives while busy.

Parameters:
- MUL_LAT, 3, cycles from multiply acceptance to HI/LO update (legal range 1..15).
- DIV_STEPS, 32, restoring-divide iterations; fixed, not user-tunable.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  op request; held by the pipeline until accepted.
- OP  in  3  0 MULTU, 1 MULT, 2 MADDU, 3 MADD, 4 DIVU, 5 DIV, 6 MTHI, 7 MTLO.
- A  in  32  rs operand (dividend / multiplicand / MT source).
- B  in  32  rt operand (divisor / multiplier).
- MF_REQ  in  1  MFHI/MFLO read request.
- MF_SEL  in  1  0 selects LO, 1 selects HI.
- BUSY  out  1  multi-cycle op in flight.
- STALL  out  1  combinational: BUSY & (START | MF_REQ).
- MF_DATA  out  32  combinational mux of HI/LO by MF_SEL; valid whenever STALL=0.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

Behaviour:
- Reset: asynchronous on RESET_N low; state IDLE, HI=0, LO=0, BUSY=0, counter 0, operand latches 0. Reset during MUL/DIV/FIX aborts the op with no HI/LO write.
- States: IDLE, MUL, DIV, FIX.
- Acceptance: START is accepted only in IDLE (BUSY=0). START while busy is not latched; STALL=1 and the pipeline holds it.
- IDLE + START, OP 6/7: HI (MTHI) or LO (MTLO) takes A at the same edge; stays IDLE; BUSY never asserts.
- IDLE + START, OP 0..3:
  - At the acceptance edge, latch A, B, OP and the 64-bit product. The product is signed for OP 1/3, unsigned for OP 0/2.
  - Go to MUL with counter = MUL_LAT-1.
  - MUL decrements the counter; at counter=0 the edge writes {HI,LO}, then returns to IDLE.
  - MULT/MULTU: {HI,LO} = product.
  - MADD/MADDU: {HI,LO} = {HI,LO} + product, modulo 2^64.
  - BUSY is high for exactly MUL_LAT cycles following acceptance.
- IDLE + START, OP 4/5:
  - Latch |A| and |B| (magnitudes for DIV, raw values for DIVU), plus sign flags qneg = A[31]^B[31] and rneg = A[31] (signed only).
  - Go to DIV with counter = 31.
  - Each DIV cycle does one restoring step: shift the remainder left, bring in the next dividend bit, trial-subtract the divisor, set the quotient bit.
  - After 32 steps, go to FIX (one cycle).
  - FIX edge writes LO = qneg ? -Q : Q and HI = rneg ? -R : R, then returns to IDLE.
  - BUSY is high for 33 cycles.
- Divide by zero (B=0, either signedness): FIX writes LO=32'hFFFF_FFFF, HI=A (raw A); latency unchanged.
- 0x8000_0000 DIV 0xFFFF_FFFF: LO=0x8000_0000, HI=0 (natural wrap, no trap).
- START in the cycle after a result write is accepted normally (one IDLE cycle minimum between ops).
- MF_REQ in the same cycle as an accepted MTHI/MTLO returns the old value; the write is visible the next cycle.
- START and MF_REQ together in IDLE: both proceed; MF_DATA shows the pre-op HI/LO.
- HI/LO hold their values in all states except at the write edges listed above.

Decomposition:
- Package muldiv_pkg holds:
  - op_t enum (the eight OP codes).
  - state_t enum {IDLE, MUL, DIV, FIX}.
  - DIV_STEPS constant.
  - helper function is_signed(op_t).
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: remainder[31:0], dividend bit, divisor[31:0].
  - Outputs: next remainder[31:0], quotient bit.
  - The carry-out of the 33-bit trial subtract decides the quotient bit.
- The sequencer instantiates div_step once.

Test Plan:
- MULTU A=0xFFFF_FFFF B=2, MUL_LAT=3 -> BUSY high 3 cycles; then HI=1, LO=0xFFFF_FFFE.
- MULT A=-3 B=5, then MADD A=2 B=4 -> after the first op HI=0xFFFF_FFFF, LO=0xFFFF_FFF1; after the second HI=0xFFFF_FFFF, LO=0xFFFF_FFF9.
- DIV A=-7 B=2 -> BUSY 33 cycles; LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- DIVU A=0x1234 B=0 -> LO=0xFFFF_FFFF, HI=0x1234 after 33 cycles.
- MF_REQ (MF_SEL=0) and a second START asserted during a DIV -> STALL=1 every busy cycle; after completion the MF read returns the new LO and the second op is accepted the next cycle.
- RESET_N pulsed low at DIV step 10 -> immediately BUSY=0, HI=LO=0, state IDLE; MTLO A=0x55 afterwards -> LO=0x55 next cycle.
